// File: rtl/paso_pkg.sv
// Shared types and phase tables for the stepper driver.
// HALF_STEP_EN selects the 8-entry half-step table and a 3-bit phase index.
package paso_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_e;

  localparam logic [1:0] CMD_MOVE = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b00;

`ifdef HALF_STEP_EN
  localparam bit HALF_STEP = 1'b1;
`else
  localparam bit HALF_STEP = 1'b0;
`endif

  localparam int unsigned PHASE_W = HALF_STEP ? 3 : 2;

  // Entry 0 sits in the least significant nibble; CCW walks upward.
  localparam logic [15:0] FULL_STEP_TBL = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
  localparam logic [31:0] HALF_STEP_TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                           4'b0110, 4'b0100, 4'b1100, 4'b1000};

  function automatic logic [3:0] phase_coil(input logic [PHASE_W-1:0] idx);
    if (HALF_STEP) begin
      return HALF_STEP_TBL[{idx, 2'b00} +: 4];
    end else begin
      return FULL_STEP_TBL[{idx[1:0], 2'b00} +: 4];
    end
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Step-rate divider: one-cycle tick every CLK_DIV enabled cycles, synchronous clear.
module divisor_tick #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = run && !clr && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/driver_paso_motor.sv
// One-axis unipolar stepper driver with degree position tracking.
// Define HALF_STEP_EN for half-step phase sequencing.
module driver_paso_motor
  import paso_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 50000,
  parameter int unsigned STEPS_PER_DEG = 4,
  parameter int unsigned POS_MAX       = 359,
  parameter int unsigned POS_INIT      = 0,
  parameter bit          WRAP          = 1'b1,
  parameter int unsigned DEAD_CYC      = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  cmd_pos,
  input  logic [1:0]  cmd_neg,
  output logic [3:0]  coil,
  output logic [15:0] pos_actual,
  output logic        busy,
  output logic        at_limit,
  output logic        cmd_err
);

  localparam int unsigned STEP_W = $clog2(STEPS_PER_DEG + 1) + 1;
  localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [STEP_W-1:0] SPD_P     = STEP_W'(STEPS_PER_DEG);
  localparam logic [STEP_W-1:0] SPD_N     = STEP_W'(0) - SPD_P;
  localparam logic [15:0]       POS_TOP   = 16'(POS_MAX);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

  logic cw_dec, ccw_dec, err_dec;
  logic cw_q, ccw_q, err_q;
  state_e state_q, state_d;
  logic dir_q, dir_d;  // 1 = CCW
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [PHASE_W-1:0] idx_q, idx_d;
  logic energised_q, energised_d;
  logic [STEP_W-1:0] step_q, step_d, step_up, step_dn;
  logic [15:0] pos_q, pos_d;
  logic at_limit_q, at_limit_d;
  logic [3:0] coil_q, coil_d;
  logic tick, step_now, blocked;

  always_comb begin
    cw_dec  = (cmd_pos == CMD_MOVE) && (cmd_neg == CMD_STOP);
    ccw_dec = (cmd_neg == CMD_MOVE) && (cmd_pos == CMD_STOP);
    err_dec = !(cw_dec || ccw_dec) && !((cmd_pos == CMD_STOP) && (cmd_neg == CMD_STOP));
  end

  divisor_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .clr (state_q != RUN),
    .run (state_q == RUN),
    .tick(tick)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    dead_d      = '0;
    idx_d       = idx_q;
    energised_d = energised_q;
    step_d      = step_q;
    pos_d       = pos_q;
    step_now    = 1'b0;
    blocked     = 1'b0;
    step_up     = step_q + STEP_W'(1);
    step_dn     = step_q - STEP_W'(1);

    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cw_q || ccw_q) begin
            state_d = RUN;
            dir_d   = ccw_q;
          end
        end
        RUN: begin
          if (!(cw_q || ccw_q)) begin
            state_d = IDLE;
          end else if (ccw_q != dir_q) begin
            state_d = DEAD;
          end else begin
            step_now = tick;
          end
        end
        DEAD: begin
          if (!(cw_q || ccw_q)) begin
            state_d = IDLE;
          end else if (dead_q == DEAD_LAST) begin
            state_d = RUN;
            dir_d   = ccw_q;
          end else begin
            dead_d = dead_q + DEAD_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Sub-degree count is signed so a reversal unwinds partial degrees.
    if (step_now) begin
      if (dir_q) begin
        blocked = !WRAP && (pos_q == POS_TOP) && !step_q[STEP_W-1];
        if (!blocked) begin
          if (energised_q) idx_d = idx_q + PHASE_W'(1);
          if (step_up == SPD_P) begin
            step_d = '0;
            pos_d  = (pos_q == POS_TOP) ? 16'd0 : pos_q + 16'd1;
          end else begin
            step_d = step_up;
          end
        end
      end else begin
        blocked = !WRAP && (pos_q == 16'd0) && (step_q[STEP_W-1] || (step_q == '0));
        if (!blocked) begin
          if (energised_q) idx_d = idx_q - PHASE_W'(1);
          if (step_dn == SPD_N) begin
            step_d = '0;
            pos_d  = (pos_q == 16'd0) ? POS_TOP : pos_q - 16'd1;
          end else begin
            step_d = step_dn;
          end
        end
      end
      // The first transition after reset energises the current phase.
      energised_d = energised_q || !blocked;
    end

    at_limit_d = (state_d == RUN) && (blocked || at_limit_q);
    coil_d     = (enable && energised_d) ? phase_coil(idx_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cw_q        <= 1'b0;
      ccw_q       <= 1'b0;
      err_q       <= 1'b0;
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      dead_q      <= '0;
      idx_q       <= '0;
      energised_q <= 1'b0;
      step_q      <= '0;
      pos_q       <= 16'(POS_INIT);
      at_limit_q  <= 1'b0;
      coil_q      <= 4'b0000;
    end else begin
      cw_q        <= cw_dec;
      ccw_q       <= ccw_dec;
      err_q       <= err_dec;
      state_q     <= state_d;
      dir_q       <= dir_d;
      dead_q      <= dead_d;
      idx_q       <= idx_d;
      energised_q <= energised_d;
      step_q      <= step_d;
      pos_q       <= pos_d;
      at_limit_q  <= at_limit_d;
      coil_q      <= coil_d;
    end
  end

  assign coil       = coil_q;
  assign pos_actual = pos_q;
  assign busy       = (state_q == RUN) || (state_q == DEAD);
  assign at_limit   = at_limit_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_driver_paso_motor.sv
// Directed bench: wrapping axis instance plus a saturating instance for limit blocking.
module tb_driver_paso_motor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  cmd_pos = 2'b00;
  logic [1:0]  cmd_neg = 2'b00;
  logic [3:0]  coil;
  logic [15:0] pos_actual;
  logic        busy, at_limit, cmd_err;

  logic [1:0]  cmd_pos_l = 2'b00;
  logic [3:0]  coil_l;
  logic [15:0] pos_l;
  logic        busy_l, at_limit_l, cmd_err_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  driver_paso_motor #(
    .CLK_DIV(4), .STEPS_PER_DEG(2), .POS_MAX(359), .POS_INIT(0), .WRAP(1'b1), .DEAD_CYC(3)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_pos(cmd_pos), .cmd_neg(cmd_neg),
    .coil(coil), .pos_actual(pos_actual), .busy(busy), .at_limit(at_limit), .cmd_err(cmd_err)
  );

  driver_paso_motor #(
    .CLK_DIV(4), .STEPS_PER_DEG(2), .POS_MAX(359), .POS_INIT(0), .WRAP(1'b0), .DEAD_CYC(3)
  ) u_lim (
    .clk(clk), .rst(rst), .enable(1'b1), .cmd_pos(cmd_pos_l), .cmd_neg(2'b00),
    .coil(coil_l), .pos_actual(pos_l), .busy(busy_l), .at_limit(at_limit_l), .cmd_err(cmd_err_l)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_coil", 16'(coil), 16'h0);
    chk("rst_pos", pos_actual, 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_err", 16'(cmd_err), 16'd0);
    chk("rst_lim", 16'(at_limit), 16'd0);
    rst = 1'b0;
    cyc(1);

    // CCW run: entry two edges after the command, steps every 4 cycles.
    cmd_neg = 2'b01;
    cyc(1); chk("ccw_busy_e1", 16'(busy), 16'd0);
    cyc(1); chk("ccw_busy_e2", 16'(busy), 16'd1);
    chk("ccw_coil_e2", 16'(coil), 16'h0);
    cyc(3); chk("ccw_coil_e5", 16'(coil), 16'h0);
    cyc(1); chk("ccw_s1", 16'(coil), 16'hC); chk("ccw_p1", pos_actual, 16'd0);
    cyc(4); chk("ccw_s2", 16'(coil), 16'h6); chk("ccw_p2", pos_actual, 16'd1);
    cyc(4); chk("ccw_s3", 16'(coil), 16'h3); chk("ccw_busy_s3", 16'(busy), 16'd1);
    cyc(4); chk("ccw_s4", 16'(coil), 16'h9); chk("ccw_p4", pos_actual, 16'd2);

    // Reversal: dead time then CW back through 0 and wrap to 359.
    cmd_neg = 2'b00; cmd_pos = 2'b01;
    cyc(2); chk("dead_busy", 16'(busy), 16'd1); chk("dead_coil", 16'(coil), 16'h9);
    cyc(6); chk("rev_hold", 16'(coil), 16'h9);
    cyc(1); chk("rev_s1", 16'(coil), 16'h3); chk("rev_p1", pos_actual, 16'd2);
    cyc(4); chk("rev_s2", 16'(coil), 16'h6); chk("rev_p2", pos_actual, 16'd1);
    cyc(8); chk("rev_s4", 16'(coil), 16'h9); chk("rev_p4", pos_actual, 16'd0);
    cyc(4); chk("wrap_s1", 16'(coil), 16'h3); chk("wrap_p1", pos_actual, 16'd0);
    cyc(4); chk("wrap_s2", 16'(coil), 16'h6); chk("wrap_p2", pos_actual, 16'd359);

    // Stop: back to IDLE, holding phase.
    cmd_pos = 2'b00;
    cyc(2); chk("stop_busy", 16'(busy), 16'd0); chk("stop_coil", 16'(coil), 16'h6);
    chk("stop_pos", pos_actual, 16'd359);

    // Invalid command combination.
    cmd_pos = 2'b01; cmd_neg = 2'b01;
    cyc(1); chk("err_set", 16'(cmd_err), 16'd1);
    cyc(5); chk("err_busy", 16'(busy), 16'd0); chk("err_coil", 16'(coil), 16'h6);
    cmd_pos = 2'b00; cmd_neg = 2'b00;
    cyc(1); chk("err_clr", 16'(cmd_err), 16'd0);

    // CCW wrap 359 -> 0, then enable drop and resume.
    cmd_neg = 2'b01;
    cyc(6); chk("ccw2_s1", 16'(coil), 16'h3); chk("ccw2_p1", pos_actual, 16'd359);
    cyc(4); chk("ccw2_s2", 16'(coil), 16'h9); chk("ccw2_p2", pos_actual, 16'd0);
    enable = 1'b0;
    cyc(1); chk("dis_coil", 16'(coil), 16'h0); chk("dis_busy", 16'(busy), 16'd0);
    chk("dis_pos", pos_actual, 16'd0);
    cyc(2); chk("dis_coil2", 16'(coil), 16'h0);
    enable = 1'b1;
    cyc(1); chk("en_coil", 16'(coil), 16'h9); chk("en_busy", 16'(busy), 16'd1);
    cyc(4); chk("en_s1", 16'(coil), 16'hC); chk("en_p1", pos_actual, 16'd0);
    cyc(4); chk("en_s2", 16'(coil), 16'h6); chk("en_p2", pos_actual, 16'd1);

    // Reset mid-run.
    rst = 1'b1;
    cyc(1); chk("mrst_coil", 16'(coil), 16'h0); chk("mrst_pos", pos_actual, 16'd0);
    chk("mrst_busy", 16'(busy), 16'd0); chk("mrst_err", 16'(cmd_err), 16'd0);
    rst = 1'b0; cmd_neg = 2'b00;
    cyc(1);

    // Saturating instance: CW from 0 is blocked.
    cmd_pos_l = 2'b01;
    cyc(5); chk("lim_busy_e5", 16'(busy_l), 16'd1); chk("lim_flag_e5", 16'(at_limit_l), 16'd0);
    cyc(1); chk("lim_flag", 16'(at_limit_l), 16'd1); chk("lim_coil", 16'(coil_l), 16'h0);
    chk("lim_pos", pos_l, 16'd0);
    cyc(4); chk("lim_flag2", 16'(at_limit_l), 16'd1); chk("lim_busy2", 16'(busy_l), 16'd1);
    chk("lim_coil2", 16'(coil_l), 16'h0); chk("lim_err", 16'(cmd_err_l), 16'd0);
    cmd_pos_l = 2'b00;
    cyc(2); chk("lim_clr", 16'(at_limit_l), 16'd0); chk("lim_idle", 16'(busy_l), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
